// File: rtl/req_ack_responder_if.sv
// rtl/req_ack_responder_if.sv - req/ack handshake bundle between an initiator and a responder
interface req_ack_responder_if #(
  parameter int DATA_W = 8
);
  logic              req;
  logic [DATA_W-1:0] req_data;
  logic              ack;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req,
    output req_data,
    input  ack,
    input  rsp_data
  );

  modport slave (
    input  req,
    input  req_data,
    output ack,
    output rsp_data
  );
endinterface

// File: rtl/req_ack_responder.sv
// rtl/req_ack_responder.sv - four-phase req/ack responder with programmable ack delay
// Optional REQ_SYNC_EN: 2-flop synchroniser on req (adds 2 cycles to every req latency).
module req_ack_responder #(
  parameter int DATA_W    = 8,
  parameter int ACK_DELAY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  req_ack_responder_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] txn_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  // Delay counter is loaded with ACK_DELAY-1; with no delay WAIT is skipped entirely.
  localparam logic [7:0] CNT_LOAD = (ACK_DELAY == 0) ? 8'd0 : 8'(ACK_DELAY - 1);
  localparam logic       NO_DELAY = (ACK_DELAY == 0);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic [CNT_W-1:0]  txn_q, txn_d;
  logic              req_s;

`ifdef REQ_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.req};
    end
  end

  assign req_s = sync_q[1];
`else
  assign req_s = bus.req;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rsp_q   <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
      txn_q   <= txn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          state_d = NO_DELAY ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is computed here as a next value and registered above,
  // so req never reaches an output combinationally.
  always_comb begin
    cnt_d  = cnt_q;
    ack_d  = ack_q;
    rsp_d  = rsp_q;
    txn_d  = txn_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          rsp_d = bus.req_data;
          cnt_d = CNT_LOAD;
          ack_d = NO_DELAY;
        end
      end
      S_WAIT: begin
        if (!req_s) begin
          err_d = 1'b1;
        end else if (cnt_q == 8'd0) begin
          ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACK: begin
        if (!req_s) begin
          ack_d  = 1'b0;
          done_d = 1'b1;
          txn_d  = txn_q + 1'b1;
        end
      end
      default: begin
        ack_d = 1'b0;
      end
    endcase
  end

  assign bus.ack      = ack_q;
  assign bus.rsp_data = rsp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign txn_cnt      = txn_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// tb/tb_req_ack_responder.sv - self-checking bench for req_ack_responder (delay 2 and delay 0 instances)
module tb_req_ack_responder;

  localparam int AD = 2;
`ifdef REQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk;
  logic       rstn;
  logic       busy, done, err;
  logic [7:0] txn_cnt;
  logic       busy0, done0, err0;
  logic [7:0] txn_cnt0;

  int         n_vec;
  int         n_err;
  logic [7:0] exp_cnt;
  logic [7:0] last_data;
  logic [15:0] sb[$];

  req_ack_responder_if #(.DATA_W(8)) bif ();
  req_ack_responder_if #(.DATA_W(8)) bif0 ();

  req_ack_responder #(.DATA_W(8), .ACK_DELAY(AD), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .bus(bif),
    .busy(busy), .done(done), .err(err), .txn_cnt(txn_cnt)
  );

  req_ack_responder #(.DATA_W(8), .ACK_DELAY(0), .CNT_W(8)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bif0),
    .busy(busy0), .done(done0), .err(err0), .txn_cnt(txn_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise req with data, expect ack exactly AD(+SL) edges after acceptance.
  task automatic start_req(input logic [7:0] data);
    logic [7:0] nxt;
    nxt = exp_cnt + 8'd1;
    bif.req = 1'b1;
    bif.req_data = data;
    last_data = data;
    sb.push_back({nxt, data});
    for (int j = 0; j <= AD + SL; j++) begin
      @(negedge clk);
      n_vec++;
      if (bif.ack !== (j == AD + SL)) begin
        n_err++;
        $display("FAIL ack_rise j=%0d data=%h: got %b want %b", j, data, bif.ack, (j == AD + SL));
      end
      if (j == 0) begin
        n_vec++;
        if (done !== 1'b0) begin
          n_err++;
          $display("FAIL done_low_at_start: got %b want 0", done);
        end
        if (SL == 0) bif.req_data = ~data;
      end
    end
    n_vec++;
    if (bif.rsp_data !== data || busy !== 1'b1) begin
      n_err++;
      $display("FAIL capture: rsp_data %h busy %b, want %h 1", bif.rsp_data, busy, data);
    end
  endtask

  // Drop req, expect ack fall and done pulse SL edges later; pop scoreboard on done.
  task automatic end_req();
    logic [15:0] e;
    bif.req = 1'b0;
    for (int j = 0; j <= SL; j++) begin
      @(negedge clk);
      n_vec++;
      if (bif.ack !== (j < SL) || done !== (j == SL)) begin
        n_err++;
        $display("FAIL ack_fall j=%0d: ack %b done %b, want %b %b", j, bif.ack, done, (j < SL), (j == SL));
      end
    end
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: done seen with no pending transaction");
    end else begin
      e = sb.pop_front();
      if (bif.rsp_data !== e[7:0] || txn_cnt !== e[15:8] || busy !== 1'b0) begin
        n_err++;
        $display("FAIL completion: rsp_data %h txn_cnt %0d busy %b, want %h %0d 0",
                 bif.rsp_data, txn_cnt, busy, e[7:0], e[15:8]);
      end
      exp_cnt = e[15:8];
    end
  endtask

  task automatic do_txn(input logic [7:0] data);
    start_req(data);
    end_req();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bif.req = 1'b1;
    bif.req_data = 8'h5A;
    bif0.req = 1'b0;
    bif0.req_data = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bif.ack !== 1'b0 || busy !== 1'b0 || bif.rsp_data !== 8'h00 ||
        txn_cnt !== 8'h00 || err !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: ack %b busy %b rsp %h cnt %0d err %b done %b, want all 0",
               bif.ack, busy, bif.rsp_data, txn_cnt, err, done);
    end
    bif.req = 1'b0;
    exp_cnt = 8'd0;
    last_data = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_txn(8'hA5);
    n_vec++;
    if (txn_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL basic_txn_cnt: got %0d want 1", txn_cnt);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_one_cycle: got %b want 0", done);
    end
  endtask

  task automatic test_early_drop();
    bif.req = 1'b1;
    bif.req_data = last_data;
    @(negedge clk);
    bif.req = 1'b0;
    for (int j = 0; j <= 1 + SL; j++) begin
      if (j > 0) @(negedge clk);
      n_vec++;
      if (bif.ack !== 1'b0 || err !== (j == 1 + SL)) begin
        n_err++;
        $display("FAIL early_drop j=%0d: ack %b err %b, want 0 %b", j, bif.ack, err, (j == 1 + SL));
      end
    end
    @(negedge clk);
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b0 || txn_cnt !== exp_cnt || bif.rsp_data !== last_data) begin
      n_err++;
      $display("FAIL early_drop_after: err %b busy %b cnt %0d rsp %h, want 0 0 %0d %h",
               err, busy, txn_cnt, bif.rsp_data, exp_cnt, last_data);
    end
  endtask

  task automatic test_back_to_back();
    do_txn(8'h01);
    do_txn(8'h02);
    do_txn(8'h03);
    n_vec++;
    if (bif.rsp_data !== 8'h03 || txn_cnt !== 8'd4) begin
      n_err++;
      $display("FAIL back_to_back: rsp %h cnt %0d, want 03 4", bif.rsp_data, txn_cnt);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start_req(8'h3C);
    #2;
    rstn = 1'b0;
    #1;
    n_vec++;
    if (bif.ack !== 1'b0 || busy !== 1'b0 || txn_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset: ack %b busy %b cnt %0d, want 0 0 0", bif.ack, busy, txn_cnt);
    end
    sb.delete();
    exp_cnt = 8'd0;
    @(negedge clk);
    rstn = 1'b1;
    do_txn(8'hC3);
    n_vec++;
    if (txn_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL reset_rearm_cnt: got %0d want 1", txn_cnt);
    end
  endtask

  task automatic test_wrap();
    while (exp_cnt != 8'hFF) do_txn(8'($urandom));
    do_txn(8'hEE);
    n_vec++;
    if (txn_cnt !== 8'h00 || bif.rsp_data !== 8'hEE) begin
      n_err++;
      $display("FAIL wrap: cnt %0d rsp %h, want 0 ee", txn_cnt, bif.rsp_data);
    end
  endtask

  task automatic test_zero_delay();
    @(negedge clk);
    bif0.req = 1'b1;
    bif0.req_data = 8'h77;
    for (int j = 0; j <= SL; j++) begin
      @(negedge clk);
      n_vec++;
      if (bif0.ack !== (j == SL)) begin
        n_err++;
        $display("FAIL zero_delay_ack j=%0d: got %b want %b", j, bif0.ack, (j == SL));
      end
    end
    n_vec++;
    if (bif0.rsp_data !== 8'h77) begin
      n_err++;
      $display("FAIL zero_delay_rsp: got %h want 77", bif0.rsp_data);
    end
    bif0.req = 1'b0;
    for (int j = 0; j <= SL; j++) begin
      @(negedge clk);
      n_vec++;
      if (bif0.ack !== (j < SL) || done0 !== (j == SL)) begin
        n_err++;
        $display("FAIL zero_delay_done j=%0d: ack %b done %b, want %b %b", j, bif0.ack, done0, (j < SL), (j == SL));
      end
    end
    n_vec++;
    if (txn_cnt0 !== 8'd1 || err0 !== 1'b0) begin
      n_err++;
      $display("FAIL zero_delay_cnt: cnt %0d err %b, want 1 0", txn_cnt0, err0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_cnt = 8'd0;
    last_data = 8'h00;
    test_reset();
    test_basic();
    test_early_drop();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    test_zero_delay();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
